// File: rtl/ps2_scancode_decoder_if.sv
// PS/2 scancode decoder bus: controller frame handshake plus key-event FIFO port.
// The master side is the controller/host, the slave side is the decoder.
interface ps2_scancode_decoder_if #(
  parameter int AW = 3
);
  logic [10:0] iFrame;
  logic        iFrame_Ready;
  logic        oFrame_Ack;
  logic [7:0]  oKey_Code;
  logic        oKey_Extended;
  logic        oKey_Break;
  logic        oKey_Valid;
  logic        iKey_Pop;
  logic [AW:0] oFifo_Count;
  logic        oOverflow;
  logic [7:0]  oError_Count;

  modport master (
    output iFrame, iFrame_Ready, iKey_Pop,
    input  oFrame_Ack, oKey_Code, oKey_Extended,
    input  oKey_Break, oKey_Valid, oFifo_Count,
    input  oOverflow, oError_Count
  );

  modport slave (
    input  iFrame, iFrame_Ready, iKey_Pop,
    output oFrame_Ack, oKey_Code, oKey_Extended,
    output oKey_Break, oKey_Valid, oFifo_Count,
    output oOverflow, oError_Count
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 frame checker and E0/F0 prefix folder.
// Completed key events are queued in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic                  Clock,
  input logic                  Reset,
  ps2_scancode_decoder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ACK
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [10:0]   frame_q, frame_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [7:0]    err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  logic       rise, frm_ok, empty, full;
  logic       pop, push, wr_en;
  logic       is_e0, is_f0, is_key;
  logic [7:0] byte_w;

  assign rise   = s2_q & ~s3_q;
  assign byte_w = frame_q[8:1];
  assign frm_ok = ~frame_q[0] & frame_q[10]
                & (^frame_q[9:1]);
  assign is_e0  = frm_ok & (byte_w == 8'hE0);
  assign is_f0  = frm_ok & (byte_w == 8'hF0);
  assign is_key = frm_ok & ~is_e0 & ~is_f0;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign pop    = bus.iKey_Pop & ~empty;
  // A same-cycle pop frees the slot before the push lands.
  assign wr_en  = push & (~full | pop);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= IDLE;
      frame_q <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= bus.iFrame_Ready;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      frame_q <= frame_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          frame_d = bus.iFrame;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = ACK;
        unique case (1'b1)
          is_e0: ext_d = 1'b1;
          is_f0: brk_d = 1'b1;
          is_key: begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (full && !pop) ovf_d = 1'b1;
          end
          default: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        endcase
      end
      ACK: begin
        if (!s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= {ext_q, brk_q, byte_w};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign {bus.oKey_Extended, bus.oKey_Break, bus.oKey_Code} =
    empty ? 10'd0 : mem_q[rd_q];
  assign bus.oKey_Valid   = ~empty;
  assign bus.oFifo_Count  = cnt_q;
  assign bus.oFrame_Ack   = (state_q != IDLE);
  assign bus.oOverflow    = ovf_q;
  assign bus.oError_Count = err_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: vector table plus
// hand-timed sequences for latency, overflow, pop-in-check and reset.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder_if #(.AW(AW)) bus ();

  ps2_scancode_decoder #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] d;
    bit         bp;
    bit         bs;
    bit         v;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    int         cnt;
    int         err;
    int         npop;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d,
                                     input bit bp,
                                     input bit bs);
    logic par;
    par = (~^d) ^ bp;
    return {~bs, par, d, 1'b0};
  endfunction

  task automatic pop1();
    @(posedge clk); #1;
    bus.iKey_Pop = 1'b1;
    @(posedge clk); #1;
    bus.iKey_Pop = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ack_low(input string nm);
    int n;
    n = 0;
    while (bus.oFrame_Ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, bus.oFrame_Ack}, 32'd0);
  endtask

  // One handshaked frame; optional pop in the CHECK cycle and
  // optional cycle-exact latency checks.
  task automatic frame_xfer(input logic [10:0] f,
                            input bit pop_chk,
                            input bit lat);
    @(posedge clk); #1;
    bus.iFrame       = f;
    bus.iFrame_Ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (lat) chk("lat_ack_e1", {31'd0, bus.oFrame_Ack}, 0);
    @(posedge clk); #1;
    if (pop_chk) bus.iKey_Pop = 1'b1;
    @(negedge clk);
    if (lat) begin
      chk("lat_ack_e2", {31'd0, bus.oFrame_Ack}, 1);
      chk("lat_val_e2", {31'd0, bus.oKey_Valid}, 0);
    end
    @(posedge clk); #1;
    bus.iKey_Pop = 1'b0;
    @(negedge clk);
    chk("ack_seen", {31'd0, bus.oFrame_Ack}, 1);
    if (lat) begin
      chk("lat_val_e3", {31'd0, bus.oKey_Valid}, 1);
      chk("lat_code", {24'd0, bus.oKey_Code}, 32'h1C);
      chk("lat_cnt", {28'd0, bus.oFifo_Count}, 1);
    end
    bus.iFrame_Ready = 1'b0;
    wait_ack_low("ack_release");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1, 0, 1};
    vecs[1]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
    vecs[2]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0};
    vecs[3]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 1, 0, 1};
    vecs[4]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0};
    vecs[5]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0};
    vecs[6]  = '{8'h1C, 0, 1, 0, 8'h00, 0, 0, 0, 2, 0};
    vecs[7]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1, 2, 1};
    vecs[8]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 2, 0};
    vecs[9]  = '{8'h6B, 0, 0, 1, 8'h6B, 1, 0, 1, 2, 0};
    vecs[10] = '{8'hAA, 0, 0, 1, 8'h6B, 1, 0, 2, 2, 1};
    vecs[11] = '{8'hFA, 0, 0, 1, 8'hAA, 0, 0, 2, 2, 1};
    vecs[12] = '{8'hE1, 0, 0, 1, 8'hFA, 0, 0, 2, 2, 2};

    bus.iFrame       = '0;
    bus.iFrame_Ready = 1'b0;
    bus.iKey_Pop     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, bus.oFrame_Ack}, 0);
    chk("rst_valid", {31'd0, bus.oKey_Valid}, 0);
    chk("rst_code", {24'd0, bus.oKey_Code}, 0);
    chk("rst_cnt", {28'd0, bus.oFifo_Count}, 0);
    chk("rst_ovf", {31'd0, bus.oOverflow}, 0);
    chk("rst_err", {24'd0, bus.oError_Count}, 0);

    frame_xfer(mk(8'h1C, 0, 0), 0, 1);
    pop1();
    @(negedge clk);
    chk("lat_popped", {28'd0, bus.oFifo_Count}, 0);

    for (int i = 0; i < 13; i++) begin
      frame_xfer(mk(vecs[i].d, vecs[i].bp, vecs[i].bs), 0, 0);
      chk($sformatf("v%0d_valid", i),
          {31'd0, bus.oKey_Valid}, {31'd0, vecs[i].v});
      chk($sformatf("v%0d_code", i),
          {24'd0, bus.oKey_Code}, {24'd0, vecs[i].code});
      chk($sformatf("v%0d_ext", i),
          {31'd0, bus.oKey_Extended}, {31'd0, vecs[i].ext});
      chk($sformatf("v%0d_brk", i),
          {31'd0, bus.oKey_Break}, {31'd0, vecs[i].brk});
      chk($sformatf("v%0d_cnt", i),
          {28'd0, bus.oFifo_Count}, vecs[i].cnt);
      chk($sformatf("v%0d_err", i),
          {24'd0, bus.oError_Count}, vecs[i].err);
      for (int k = 0; k < vecs[i].npop; k++) pop1();
    end
    @(negedge clk);
    chk("tbl_empty", {31'd0, bus.oKey_Valid}, 0);

    for (int i = 0; i <= DEPTH; i++) begin
      frame_xfer(mk(8'h10 + 8'(i), 0, 0), 0, 0);
    end
    chk("ovf_cnt", {28'd0, bus.oFifo_Count}, DEPTH);
    chk("ovf_flag", {31'd0, bus.oOverflow}, 1);
    chk("ovf_head", {24'd0, bus.oKey_Code}, 32'h10);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d", i),
          {24'd0, bus.oKey_Code}, 32'h10 + i);
      pop1();
    end
    @(negedge clk);
    chk("drain_valid", {31'd0, bus.oKey_Valid}, 0);
    chk("drain_cnt", {28'd0, bus.oFifo_Count}, 0);
    chk("ovf_sticky", {31'd0, bus.oOverflow}, 1);

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      frame_xfer(mk(8'h20 + 8'(i), 0, 0), 0, 0);
    end
    frame_xfer(mk(8'h55, 0, 0), 1, 0);
    chk("pic_cnt", {28'd0, bus.oFifo_Count}, DEPTH);
    chk("pic_ovf", {31'd0, bus.oOverflow}, 0);
    chk("pic_head", {24'd0, bus.oKey_Code}, 32'h21);
    repeat (DEPTH - 1) pop1();
    @(negedge clk);
    chk("pic_tail", {24'd0, bus.oKey_Code}, 32'h55);
    chk("pic_left", {28'd0, bus.oFifo_Count}, 1);
    pop1();

    @(posedge clk); #1;
    bus.iFrame       = mk(8'h1C, 0, 0);
    bus.iFrame_Ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ra_pre_ack", {31'd0, bus.oFrame_Ack}, 1);
    chk("ra_pre_cnt", {28'd0, bus.oFifo_Count}, 1);
    rst = 1'b1;
    #1;
    chk("ra_ack", {31'd0, bus.oFrame_Ack}, 0);
    chk("ra_valid", {31'd0, bus.oKey_Valid}, 0);
    chk("ra_code", {24'd0, bus.oKey_Code}, 0);
    chk("ra_cnt", {28'd0, bus.oFifo_Count}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("ra_re_cnt", {28'd0, bus.oFifo_Count}, 1);
    chk("ra_re_code", {24'd0, bus.oKey_Code}, 32'h1C);
    chk("ra_re_ack", {31'd0, bus.oFrame_Ack}, 1);
    bus.iFrame_Ready = 1'b0;
    wait_ack_low("ra_release");
    repeat (5) @(negedge clk);
    chk("ra_once", {28'd0, bus.oFifo_Count}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
